// File: rtl/ifft32_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ifft32_pkg                                                 |
// | Description : Shared constants, bank state encoding and bit-reversal     |
// |               helpers for the 32-point IFFT output reorder block.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package ifft32_pkg;

  localparam int DW    = 14;     // component width, signed S4.9
  localparam int N     = 32;     // IFFT size
  localparam int LOGN  = 5;      // log2(N)
  localparam int BEATS = N / 2;  // two-lane beats per frame

  // Per-bank occupancy state
  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_t;

  function automatic logic [3:0] bitrev4(input logic [3:0] x);
    return {x[0], x[1], x[2], x[3]};
  endfunction

  function automatic logic [4:0] bitrev5(input logic [4:0] x);
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/reorder_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : reorder_bank                                               |
// | Description : 32-entry register file, two write ports (upper/lower lane) |
// |               sharing one enable, one asynchronous read port.            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk        in   clock                                                  |
// |   we         in   write both lanes this cycle                            |
// |   wr_addr_u  in   bin written by the upper lane                          |
// |   wr_addr_l  in   bin written by the lower lane                          |
// |   wr_data_u  in   {real, imag} for the upper lane                        |
// |   wr_data_l  in   {real, imag} for the lower lane                        |
// |   rd_addr    in   bin to read                                            |
// |   rd_data    out  {real, imag} at rd_addr                                |
// +--------------------------------------------------------------------------+
module reorder_bank
  import ifft32_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [LOGN-1:0]   wr_addr_u,
  input  logic [LOGN-1:0]   wr_addr_l,
  input  logic [2*DW-1:0]   wr_data_u,
  input  logic [2*DW-1:0]   wr_data_l,
  input  logic [LOGN-1:0]   rd_addr,
  output logic [2*DW-1:0]   rd_data
);

  logic [2*DW-1:0] r_mem [N];

  // The two lanes of one beat always target bins b and b+16, so the write
  // addresses never collide.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[wr_addr_u] <= wr_data_u;
      r_mem[wr_addr_l] <= wr_data_l;
    end
  end

  assign rd_data = r_mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/ifft32_output_reorder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ifft32_output_reorder                                      |
// | Description : Collects bit-reversed two-lane beats into a ping-pong      |
// |               buffer and replays each frame as a natural-order serial    |
// |               stream (bin 0..31) with valid/ready back-pressure.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk, rst_n          clock, asynchronous active-low reset               |
// |   in_valid/in_ready   beat handshake                                     |
// |   U_real/U_imag       upper lane sample (S4.9)                           |
// |   L_real/L_imag       lower lane sample (S4.9)                           |
// |   out_valid/out_ready sample handshake                                   |
// |   out_real/out_imag   sample, bit-exact copy of the input                |
// |   out_index           natural bin index 0..31                            |
// |   out_last            high with bin 31                                   |
// +--------------------------------------------------------------------------+
module ifft32_output_reorder
  import ifft32_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   U_real,
  input  logic [DW-1:0]   U_imag,
  input  logic [DW-1:0]   L_real,
  input  logic [DW-1:0]   L_imag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_real,
  output logic [DW-1:0]   out_imag,
  output logic [LOGN-1:0] out_index,
  output logic            out_last
);

  bank_state_t     r_bank_state [2];
  logic            r_wr_bank;
  logic            r_rd_bank;
  logic [3:0]      r_wr_cnt;
  logic [LOGN-1:0] r_rd_cnt;
  logic            r_out_valid;
  logic [DW-1:0]   r_out_real;
  logic [DW-1:0]   r_out_imag;
  logic [LOGN-1:0] r_out_index;
  logic            r_out_last;

  logic            w_wr_fire;
  logic            w_wr_last;
  logic            w_rd_avail;
  logic            w_rd_load;
  logic            w_rd_last;
  logic [1:0]      w_we;
  logic [LOGN-1:0] w_addr_u;
  logic [LOGN-1:0] w_addr_l;
  logic [2*DW-1:0] w_rd_data [2];
  logic [2*DW-1:0] w_sel_data;

  // ---------------- write side ----------------
  assign in_ready  = (r_bank_state[r_wr_bank] == EMPTY) ||
                     (r_bank_state[r_wr_bank] == FILLING);
  assign w_wr_fire = in_valid && in_ready;
  assign w_wr_last = w_wr_fire && (r_wr_cnt == 4'(BEATS - 1));
  assign w_we      = w_wr_fire ? (r_wr_bank ? 2'b10 : 2'b01) : 2'b00;
  assign w_addr_u  = {1'b0, bitrev4(r_wr_cnt)};
  assign w_addr_l  = {1'b1, bitrev4(r_wr_cnt)};

  // ---------------- read side ----------------
  // Bin 0 is always written by beat 0, so the drain may begin in the same
  // cycle the final beat of the frame is being written.
  assign w_rd_avail = (r_bank_state[r_rd_bank] == FULL) ||
                      (r_bank_state[r_rd_bank] == DRAINING) ||
                      (w_wr_last && (r_wr_bank == r_rd_bank));
  assign w_rd_load  = w_rd_avail && (!r_out_valid || out_ready);
  assign w_rd_last  = w_rd_load && (r_rd_cnt == LOGN'(N - 1));
  assign w_sel_data = w_rd_data[r_rd_bank];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    reorder_bank u_bank (
      .clk       (clk),
      .we        (w_we[b]),
      .wr_addr_u (w_addr_u),
      .wr_addr_l (w_addr_l),
      .wr_data_u ({U_real, U_imag}),
      .wr_data_l ({L_real, L_imag}),
      .rd_addr   (r_rd_cnt),
      .rd_data   (w_rd_data[b])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bank_state[0] <= EMPTY;
      r_bank_state[1] <= EMPTY;
      r_wr_bank       <= 1'b0;
      r_rd_bank       <= 1'b0;
      r_wr_cnt        <= '0;
      r_rd_cnt        <= '0;
      r_out_valid     <= 1'b0;
      r_out_real      <= '0;
      r_out_imag      <= '0;
      r_out_index     <= '0;
      r_out_last      <= 1'b0;
    end else begin
      if (w_wr_fire) begin
        r_wr_cnt <= r_wr_cnt + 4'd1;
        if (w_wr_last) r_wr_bank <= ~r_wr_bank;
      end

      // Read update comes second so it overrides the FULL set when the drain
      // starts on the very cycle the frame completes.
      for (int b = 0; b < 2; b++) begin
        if (w_wr_fire && (r_wr_bank == 1'(b)))
          r_bank_state[b] <= w_wr_last ? FULL : FILLING;
        if (w_rd_load && (r_rd_bank == 1'(b)))
          r_bank_state[b] <= w_rd_last ? EMPTY : DRAINING;
      end

      if (w_rd_load) begin
        r_out_valid <= 1'b1;
        r_out_real  <= w_sel_data[2*DW-1:DW];
        r_out_imag  <= w_sel_data[DW-1:0];
        r_out_index <= r_rd_cnt;
        r_out_last  <= (r_rd_cnt == LOGN'(N - 1));
        r_rd_cnt    <= r_rd_cnt + LOGN'(1);
        if (w_rd_last) r_rd_bank <= ~r_rd_bank;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_real  = r_out_real;
  assign out_imag  = r_out_imag;
  assign out_index = r_out_index;
  assign out_last  = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_ifft32_output_reorder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_ifft32_output_reorder                                   |
// | Description : Self-checking bench for ifft32_output_reorder. A frame     |
// |               model places each accepted beat into a 32-bin array and    |
// |               queues the frame in natural order for comparison.          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_ifft32_output_reorder;

  localparam int DW = 14;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] U_real, U_imag, L_real, L_imag;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_real, out_imag;
  logic [4:0]    out_index;
  logic          out_last;

  ifft32_output_reorder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .U_real    (U_real),
    .U_imag    (U_imag),
    .L_real    (L_real),
    .L_imag    (L_imag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_real  (out_real),
    .out_imag  (out_imag),
    .out_index (out_index),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic [4:0]    idx;
    logic          last;
  } samp_t;

  typedef struct {
    logic [DW-1:0] u_re, u_im, l_re, l_im;
    int            bin_u, bin_l;
  } vec_t;

  samp_t exp_q[$];
  samp_t cap_q[$];
  logic [DW-1:0] fb_re [32];
  logic [DW-1:0] fb_im [32];
  int beat_k;
  int stall_cnt;
  int rdy_mode;     // 0: always ready, 1: random, 2: never ready
  int errors;
  int checks;
  bit bc_done;

  function automatic int brev4(input int x);
    int r = 0;
    for (int i = 0; i < 4; i++)
      if ((x >> i) & 1) r |= 1 << (3 - i);
    return r;
  endfunction

  task automatic chk(input bit ok, input string name,
                     input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents one beat and returns #1 after the edge that accepts it.
  task automatic send_beat(input logic [DW-1:0] ur, ui, lr, li);
    int t;
    t = 0;
    in_valid = 1'b1;
    U_real = ur; U_imag = ui; L_real = lr; L_imag = li;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 500) begin
        chk(1'b0, "in_ready_timeout", 32'(t), 32'd500);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_rand_frame(input bit gaps);
    for (int k = 0; k < 16; k++) begin
      if (gaps && $urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
      send_beat(DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom));
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 5000) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk(t < 5000, "drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin : main
    vec_t tbl[16];
    int   rev_tab[16];
    int   base;
    int   st0;
    int   stall_idx;
    int   t;

    errors = 0; checks = 0; beat_k = 0; stall_cnt = 0; rdy_mode = 0;
    bc_done = 1'b0;
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    U_real = '0; U_imag = '0; L_real = '0; L_imag = '0;

    #3 rst_n = 1'b0;
    #1;
    chk(out_valid == 1'b0, "rst_out_valid", 32'(out_valid), 32'd0);
    chk(out_real == '0,    "rst_out_real",  32'(out_real), 32'd0);
    chk(out_imag == '0,    "rst_out_imag",  32'(out_imag), 32'd0);
    chk(out_index == '0,   "rst_out_index", 32'(out_index), 32'd0);
    chk(out_last == 1'b0,  "rst_out_last",  32'(out_last), 32'd0);

    fork
      // Monitor / scoreboard: samples mid-cycle, away from the active edge.
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          exp_q.delete();
          beat_k = 0;
        end else begin
          if (in_valid && !in_ready) stall_cnt++;
          if (in_valid && in_ready) begin
            fb_re[brev4(beat_k)]      = U_real;
            fb_im[brev4(beat_k)]      = U_imag;
            fb_re[brev4(beat_k) + 16] = L_real;
            fb_im[brev4(beat_k) + 16] = L_imag;
            beat_k++;
            if (beat_k == 16) begin
              for (int b = 0; b < 32; b++) begin
                samp_t s;
                s.re = fb_re[b]; s.im = fb_im[b];
                s.idx = 5'(b); s.last = (b == 31);
                exp_q.push_back(s);
              end
              beat_k = 0;
            end
          end
          if (out_valid) begin
            if (exp_q.size() == 0) begin
              chk(1'b0, "spurious_out_valid", 32'(out_index), 32'd0);
            end else begin
              chk({out_real, out_imag} == {exp_q[0].re, exp_q[0].im}, "out_data",
                  32'({out_real, out_imag}), 32'({exp_q[0].re, exp_q[0].im}));
              chk({out_last, out_index} == {exp_q[0].last, exp_q[0].idx}, "out_idx_last",
                  32'({out_last, out_index}), 32'({exp_q[0].last, exp_q[0].idx}));
              if (out_ready) begin
                samp_t c;
                c.re = out_real; c.im = out_imag; c.idx = out_index; c.last = out_last;
                cap_q.push_back(c);
                void'(exp_q.pop_front());
              end
            end
          end
        end
      end
      // Consumer back-pressure
      forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
          1:       out_ready = 1'($urandom_range(0, 1));
          2:       out_ready = 1'b0;
          default: out_ready = 1'b1;
        endcase
      end
    join_none

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk(in_ready == 1'b1, "in_ready_after_reset", 32'(in_ready), 32'd1);

    // ---- Directed single frame from a vector table ----
    rev_tab = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
    for (int i = 0; i < 16; i++) begin
      tbl[i].u_re  = DW'(rev_tab[i]);
      tbl[i].u_im  = DW'(-rev_tab[i]);
      tbl[i].l_re  = DW'(rev_tab[i] + 16);
      tbl[i].l_im  = DW'(-(rev_tab[i] + 16));
      tbl[i].bin_u = rev_tab[i];
      tbl[i].bin_l = rev_tab[i] + 16;
    end
    base = cap_q.size();
    for (int i = 0; i < 16; i++) begin
      send_beat(tbl[i].u_re, tbl[i].u_im, tbl[i].l_re, tbl[i].l_im);
      if (i == 14) chk(out_valid == 1'b0, "no_early_valid", 32'(out_valid), 32'd0);
      if (i == 15) chk(out_valid == 1'b1, "first_valid_latency", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    wait_drain();
    chk(cap_q.size() == base + 32, "frame1_count", 32'(cap_q.size() - base), 32'd32);
    if (cap_q.size() == base + 32) begin
      for (int i = 0; i < 16; i++) begin
        chk({cap_q[base + tbl[i].bin_u].re, cap_q[base + tbl[i].bin_u].im} ==
            {tbl[i].u_re, tbl[i].u_im}, "tbl_upper",
            32'({cap_q[base + tbl[i].bin_u].re, cap_q[base + tbl[i].bin_u].im}),
            32'({tbl[i].u_re, tbl[i].u_im}));
        chk({cap_q[base + tbl[i].bin_l].re, cap_q[base + tbl[i].bin_l].im} ==
            {tbl[i].l_re, tbl[i].l_im}, "tbl_lower",
            32'({cap_q[base + tbl[i].bin_l].re, cap_q[base + tbl[i].bin_l].im}),
            32'({tbl[i].l_re, tbl[i].l_im}));
      end
      chk(cap_q[base + 31].last == 1'b1, "tbl_last31", 32'(cap_q[base + 31].last), 32'd1);
      chk(cap_q[base + 30].last == 1'b0, "tbl_last30", 32'(cap_q[base + 30].last), 32'd0);
    end

    // ---- Back-to-back frames, in_valid held high ----
    base = cap_q.size();
    st0  = stall_cnt;
    for (int f = 0; f < 4; f++) send_rand_frame(1'b0);
    wait_drain();
    chk(cap_q.size() == base + 128, "b2b_count", 32'(cap_q.size() - base), 32'd128);
    chk(stall_cnt > st0, "b2b_throttle", 32'(stall_cnt - st0), 32'd1);

    // ---- Consumer stalls 40 cycles mid-frame ----
    send_rand_frame(1'b0);
    repeat (8) @(posedge clk);
    #1 rdy_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    stall_idx = int'(exp_q[0].idx);
    bc_done = 1'b0;
    fork
      begin
        send_rand_frame(1'b0);
        send_rand_frame(1'b0);
        bc_done = 1'b1;
      end
    join_none
    repeat (40) @(posedge clk);
    #1;
    chk(out_valid == 1'b1, "stall_valid_held", 32'(out_valid), 32'd1);
    chk(int'(out_index) == stall_idx, "stall_index_frozen", 32'(out_index), 32'(stall_idx));
    chk(in_ready == 1'b0, "stall_in_ready_low", 32'(in_ready), 32'd0);
    rdy_mode = 0;
    t = 0;
    while (!bc_done && t < 2000) begin
      @(posedge clk); #1; t++;
    end
    chk(bc_done, "stall_send_done", 32'(bc_done), 32'd1);
    wait_drain();

    // ---- Random gaps and random back-pressure, 20 frames ----
    rdy_mode = 1;
    for (int f = 0; f < 20; f++) send_rand_frame(1'b1);
    wait_drain();
    rdy_mode = 0;

    // ---- Extreme S4.9 values ----
    base = cap_q.size();
    for (int k = 0; k < 16; k++) send_beat(14'h1FFF, 14'h2000, 14'h2000, 14'h1FFF);
    in_valid = 1'b0;
    wait_drain();
    chk(cap_q.size() == base + 32, "ext_count", 32'(cap_q.size() - base), 32'd32);
    if (cap_q.size() == base + 32) begin
      for (int b = 0; b < 32; b += 5) begin
        chk(cap_q[base + b].re == ((b < 16) ? 14'h1FFF : 14'h2000), "ext_real",
            32'(cap_q[base + b].re), 32'((b < 16) ? 14'h1FFF : 14'h2000));
      end
      chk($signed(cap_q[base + 31].re) < 0, "ext_sign", 32'(cap_q[base + 31].re), 32'h2000);
    end

    // ---- Reset at beat 7 of frame 2 while frame 1 drains ----
    send_rand_frame(1'b0);
    for (int k = 0; k < 7; k++)
      send_beat(DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom));
    in_valid = 1'b1;
    U_real = 14'h0123; U_imag = 14'h0456; L_real = 14'h0789; L_imag = 14'h0ABC;
    chk(out_valid == 1'b1, "pre_reset_draining", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk(out_valid == 1'b0, "async_reset_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk({out_index, out_last, out_real} == '0, "reset_outputs",
        32'({out_index, out_last, out_real}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk(in_ready == 1'b1, "post_reset_ready", 32'(in_ready), 32'd1);
    chk(out_valid == 1'b0, "post_reset_idle", 32'(out_valid), 32'd0);
    base = cap_q.size();
    send_rand_frame(1'b0);
    wait_drain();
    chk(cap_q.size() == base + 32, "post_reset_count", 32'(cap_q.size() - base), 32'd32);
    if (cap_q.size() > base)
      chk(cap_q[base].idx == 5'd0, "post_reset_first_idx", 32'(cap_q[base].idx), 32'd0);

    chk(exp_q.size() == 0, "scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ifft32_output_reorder.md
Name: ifft32_output_reorder

Overview:
- Final block of the 32-point IFFT pipeline; sits directly after the stage-4 lane commutator.
- Accepts two-lane (upper/lower) complex pairs arriving in bit-reversed bin order.
- Buffers them in a ping-pong RAM and emits a single serial stream in natural order, bin 0..31, with valid/ready handshake.
- Decouples the fixed-rate butterfly pipeline from a back-pressured consumer.

Parameters:
- DW, 14, width of each real/imag component (signed S4.9)
- N, 32, IFFT size; beats per frame = N/2
- LOGN, 5, log2(N)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  pair beat valid
- in_ready  out  1  block can accept pair beat
- U_real  in  DW  upper lane real, signed S4.9
- U_imag  in  DW  upper lane imag
- L_real  in  DW  lower lane real
- L_imag  in  DW  lower lane imag
- out_valid  out  1  serial sample valid
- out_ready  in  1  consumer accepts sample
- out_real  out  DW  sample real, S4.9, unmodified
- out_imag  out  DW  sample imag
- out_index  out  LOGN  bin index of current sample, 0..31
- out_last  out  1  high with bin 31

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: out_valid=0, out_real=0, out_imag=0, out_index=0, out_last=0. Both banks empty, wr_bank=0, rd_bank=0, wr_cnt=0, rd_cnt=0. in_ready=1 one cycle after release.
- Input mapping: accepted beat k (0..15) of a frame writes upper to bin bitrev4(k) and lower to bin bitrev4(k)+16.
  - Example: k=1 -> bins 8, 24; k=15 -> bins 15, 31.
- Storage: two banks of 32 x (2*DW) registers. Bank state per bank: EMPTY, FILLING, FULL, DRAINING.
- Write side:
  - Beat accepted on in_valid & in_ready.
  - wr_cnt increments per beat; on beat 15 the current bank is marked FULL, wr_cnt wraps to 0 and wr_bank toggles.
  - in_ready = (bank[wr_bank] is EMPTY or FILLING); combinational from state registers only, never from in_valid.
- Read side:
  - When bank[rd_bank] is FULL and the output register is free, reading starts.
  - The output register loads bin rd_cnt and asserts out_valid.
  - Advance occurs on out_valid & out_ready, or when out_valid=0.
  - out_real, out_imag, out_index and out_last hold stable while out_valid & !out_ready.
  - After bin 31 is loaded, the bank returns to EMPTY, rd_bank toggles and rd_cnt wraps.
- Latency: first sample of a frame is out_valid in the cycle after beat 15 is accepted, given idle output and out_ready=1.
- Throughput: 1 sample/cycle out vs 2 samples/beat in, so the input side throttles at 50% duty under sustained input. No beat is ever dropped.
- Simultaneous events:
  - A bank freed by the read side (EMPTY) in the same cycle the write side wants it becomes writable the next cycle. There is no same-cycle bypass.
  - Write completion and read completion on different banks in the same cycle are both honoured.
- Both banks FULL/DRAINING: in_ready=0 until the draining bank empties.
- Reset mid-frame discards all partial and full frames. Output drops out_valid immediately; there is no partial-frame flush.
- Data passes through unscaled, no rounding; bit-exact.

Decomposition:
- Package ifft32_pkg holds:
  - DW, N, LOGN
  - bitrev4 and bitrev5 functions
  - bank state encoding (EMPTY=2'd0, FILLING=2'd1, FULL=2'd2, DRAINING=2'd3)
- One natural sub-module: reorder_bank, a 32-entry dual-write-port (upper/lower) / single-read-port register file, instantiated twice.

Test Plan:
- Single frame, out_ready=1: beats k carry U=bitrev4(k), L=bitrev4(k)+16 (real), imag=-real -> out_index 0..31 with out_real equal to index and out_imag = -index; out_last only at 31; first out_valid one cycle after beat 15.
- Back-to-back frames, in_valid held high, 4 frames -> in_ready pattern throttles. All 128 samples are in natural order with the correct frame sequence. No loss or duplication.
- out_ready held 0 for 40 cycles mid-frame -> outputs frozen at same index/data. Second bank fills, then in_ready=0. Drain resumes exactly where it stopped.
- Random in_valid gaps and random out_ready (50%) over 20 frames -> scoreboard matches reference bit-reverse model bit-exactly.
- Extremes: U=14'h1FFF, L=14'h2000 (max/min S4.9) -> reproduced unmodified with sign intact.
- rst_n asserted at beat 7 of frame 2 while frame 1 is draining -> out_valid=0 asynchronously. After release, a fresh frame reorders correctly starting at index 0.
